// File: rtl/combination_ctrl.sv
// Sequencer for the GCN combination stage: walks each column pass, and every
// adjacency row within it, and drives the decode/read/accumulate/write strobes.
module combination_ctrl #(
   parameter int FEATURE_ROWS = 6,
   parameter int WEIGHT_COLS  = 3,
   parameter int LANES        = 1,
   parameter int ROW_W        = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
   parameter int COL_W        = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mem_ready,
   output logic             enable_decode,
   output logic             enable_read,
   output logic             enable_vector,
   output logic             enable_write,
   output logic [ROW_W-1:0] adj_addr,
   output logic [COL_W-1:0] col_base,
   output logic [LANES-1:0] lane_mask,
   output logic             busy,
   output logic             done,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_READ_FM_WM,
      S_READ_ADJ,
      S_WRITE,
      S_NEXT_COL,
      S_DONE
   } state_t;

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FEATURE_ROWS - 1);
   localparam logic [COL_W:0]   LANES_X  = (COL_W + 1)'(LANES);
   localparam logic [COL_W:0]   WCOLS_X  = (COL_W + 1)'(WEIGHT_COLS);

   state_t           state;
   state_t           state_nxt;
   logic [ROW_W-1:0] adj_q;
   logic [COL_W-1:0] col_q;
   logic             last_row;
   logic             last_pass;

   // Widened by one bit so col_base+LANES cannot wrap on the final pass.
   assign last_row  = (adj_q == LAST_ROW);
   assign last_pass = (({1'b0, col_q} + LANES_X) >= WCOLS_X);

   assign adj_addr  = adj_q;
   assign col_base  = col_q;
   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         adj_q <= '0;
         col_q <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               adj_q <= '0;
               col_q <= '0;
            end
            S_WRITE: begin
               if (!last_row) adj_q <= adj_q + ROW_W'(1);
            end
            S_NEXT_COL: begin
               adj_q <= '0;
               col_q <= col_q + COL_W'(LANES);
            end
            S_DONE: begin
               if (!start) begin
                  adj_q <= '0;
                  col_q <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // mem_ready acts as the valid half of the read handshake: a read state
   // holds all outputs until mem_ready=1 is seen on a rising edge, and that
   // edge is the only one on which the read (and enable_vector) is consumed.
   always_comb begin
      state_nxt     = state;
      enable_decode = 1'b0;
      enable_read   = 1'b0;
      enable_vector = 1'b0;
      enable_write  = 1'b0;
      busy          = 1'b1;
      done          = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = S_DECODE;
         end
         S_DECODE: begin
            enable_decode = 1'b1;
            state_nxt     = S_READ_FM_WM;
         end
         S_READ_FM_WM: begin
            enable_read = 1'b1;
            if (mem_ready) state_nxt = S_READ_ADJ;
         end
         S_READ_ADJ: begin
            enable_read   = 1'b1;
            enable_vector = 1'b1;
            if (mem_ready) state_nxt = S_WRITE;
         end
         S_WRITE: begin
            enable_write = 1'b1;
            enable_read  = 1'b1;
            if (!last_row)     state_nxt = S_READ_ADJ;
            else if (last_pass) state_nxt = S_DONE;
            else               state_nxt = S_NEXT_COL;
         end
         S_NEXT_COL: begin
            state_nxt = S_READ_FM_WM;
         end
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
            if (!start) state_nxt = S_IDLE;
         end
         default: begin
            busy      = 1'b0;
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      lane_mask = '0;
      for (int i = 0; i < LANES; i++) begin
         if (busy && (({1'b0, col_q} + (COL_W + 1)'(i)) < WCOLS_X)) lane_mask[i] = 1'b1;
      end
   end

endmodule

// File: tb/tb_combination_ctrl.sv
// Bench for combination_ctrl: three parameterisations share one stimulus
// stream and are compared every cycle against a position-based timeline model.
module tb_combination_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic mem_ready = 1'b1;

   always #5 clk = ~clk;

   // dut0: defaults (6 rows, 3 cols, 1 lane)
   logic d0_dec, d0_rd, d0_vec, d0_wr, d0_busy, d0_done;
   logic [2:0] d0_adj;
   logic [1:0] d0_col;
   logic [0:0] d0_mask;
   logic [2:0] d0_st;
   // dut1: 6 rows, 3 cols, 2 lanes
   logic d1_dec, d1_rd, d1_vec, d1_wr, d1_busy, d1_done;
   logic [2:0] d1_adj;
   logic [1:0] d1_col;
   logic [1:0] d1_mask;
   logic [2:0] d1_st;
   // dut2: 1 row, 1 col, 1 lane
   logic d2_dec, d2_rd, d2_vec, d2_wr, d2_busy, d2_done;
   logic [0:0] d2_adj;
   logic [0:0] d2_col;
   logic [0:0] d2_mask;
   logic [2:0] d2_st;

   combination_ctrl dut0 (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
      .enable_decode(d0_dec), .enable_read(d0_rd), .enable_vector(d0_vec),
      .enable_write(d0_wr), .adj_addr(d0_adj), .col_base(d0_col),
      .lane_mask(d0_mask), .busy(d0_busy), .done(d0_done), .state_dbg(d0_st)
   );

   combination_ctrl #(.FEATURE_ROWS(6), .WEIGHT_COLS(3), .LANES(2)) dut1 (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
      .enable_decode(d1_dec), .enable_read(d1_rd), .enable_vector(d1_vec),
      .enable_write(d1_wr), .adj_addr(d1_adj), .col_base(d1_col),
      .lane_mask(d1_mask), .busy(d1_busy), .done(d1_done), .state_dbg(d1_st)
   );

   combination_ctrl #(.FEATURE_ROWS(1), .WEIGHT_COLS(1), .LANES(1)) dut2 (
      .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
      .enable_decode(d2_dec), .enable_read(d2_rd), .enable_vector(d2_vec),
      .enable_write(d2_wr), .adj_addr(d2_adj), .col_base(d2_col),
      .lane_mask(d2_mask), .busy(d2_busy), .done(d2_done), .state_dbg(d2_st)
   );

   int n_checks = 0;
   int n_pass = 0;
   int n_fail = 0;

   int p_fr[3] = '{6, 6, 1};
   int p_wc[3] = '{3, 3, 1};
   int p_ln[3] = '{1, 2, 1};
   int mpos[3] = '{-1, -1, -1};   // -1 idle, 0..n-1 busy timeline slot, n done
   int since_start = -1000;
   int done_at[3];
   int wr_cnt;
   int dec_cnt;
   logic [15:0] exp_q[$];         // expected (col_base, adj_addr) per dut0 write

   // Busy timeline length: decode slot, then per pass one FM/WM read, a
   // read/write pair per row and a column step (the final pass has no step).
   function automatic int n_of(input int fr, input int wc, input int ln);
      int passes;
      passes = (wc + ln - 1) / ln;
      return passes * (2 * fr + 2);
   endfunction

   function automatic bit is_wait(input int fr, input int wc, input int ln, input int pos);
      int r;
      if (pos < 1 || pos >= n_of(fr, wc, ln)) return 1'b0;
      r = (pos - 1) % (2 * fr + 2);
      return (r == 0) || ((r % 2 == 1) && (r <= 2 * fr));
   endfunction

   // {dec, rd, vec, wr, busy, done, adj[7:0], col[7:0], mask[7:0]}
   function automatic logic [29:0] exp_rec(input int fr, input int wc, input int ln, input int pos);
      int passes, n, q, r, adj, col;
      logic dec, rd, vec, wr, bsy, dn;
      logic [7:0] mask;
      passes = (wc + ln - 1) / ln;
      n = n_of(fr, wc, ln);
      {dec, rd, vec, wr, bsy, dn} = '0;
      adj = 0;
      col = 0;
      mask = '0;
      if (pos < 0) return '0;
      if (pos >= n) begin
         dn = 1'b1;
         adj = fr - 1;
         col = (passes - 1) * ln;
      end else begin
         bsy = 1'b1;
         if (pos > 0) begin
            q = pos - 1;
            r = q % (2 * fr + 2);
            col = (q / (2 * fr + 2)) * ln;
            if (r == 0) begin
               rd = 1'b1;
            end else if (r <= 2 * fr) begin
               adj = (r - 1) / 2;
               rd = 1'b1;
               if (r % 2 == 1) vec = 1'b1;
               else wr = 1'b1;
            end else begin
               adj = fr - 1;
            end
         end else begin
            dec = 1'b1;
         end
         for (int i = 0; i < ln; i++) if (col + i < wc) mask[i] = 1'b1;
      end
      return {dec, rd, vec, wr, bsy, dn, 8'(adj), 8'(col), mask};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Drive inputs away from the edge, advance the model on the edge,
   // compare on the falling edge.
   task automatic cycle(input logic rs, input logic st, input logic mr);
      logic [29:0] obs[3];
      reset = rs;
      start = st;
      mem_ready = mr;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rs) mpos[i] = -1;
         else if (mpos[i] < 0) begin
            if (st) mpos[i] = 0;
         end else if (mpos[i] < n_of(p_fr[i], p_wc[i], p_ln[i])) begin
            if (!(is_wait(p_fr[i], p_wc[i], p_ln[i], mpos[i]) && !mr)) mpos[i]++;
         end else if (!st) mpos[i] = -1;
      end
      since_start++;
      @(negedge clk);
      obs[0] = {d0_dec, d0_rd, d0_vec, d0_wr, d0_busy, d0_done, 8'(d0_adj), 8'(d0_col), 8'(d0_mask)};
      obs[1] = {d1_dec, d1_rd, d1_vec, d1_wr, d1_busy, d1_done, 8'(d1_adj), 8'(d1_col), 8'(d1_mask)};
      obs[2] = {d2_dec, d2_rd, d2_vec, d2_wr, d2_busy, d2_done, 8'(d2_adj), 8'(d2_col), 8'(d2_mask)};
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("cycle_dut%0d", i), 64'(obs[i]), 64'(exp_rec(p_fr[i], p_wc[i], p_ln[i], mpos[i])));
         if (since_start >= 0 && done_at[i] < 0 && obs[i][24]) done_at[i] = since_start;
      end
      if (since_start >= 0) begin
         if (d0_dec) dec_cnt++;
         if (d0_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("sb_extra_write", 64'(d0_wr), 64'(0));
            else chk("sb_write_visit", 64'({8'(d0_col), 8'(d0_adj)}), 64'(exp_q.pop_front()));
         end
      end
   endtask

   task automatic start_run();
      cycle(1'b0, 1'b0, 1'b1);
      exp_q.delete();
      for (int c = 0; c < 3; c++)
         for (int r = 0; r < 6; r++) exp_q.push_back({8'(c), 8'(r)});
      for (int i = 0; i < 3; i++) done_at[i] = -1;
      wr_cnt = 0;
      dec_cnt = 0;
      since_start = -1;
      cycle(1'b0, 1'b1, 1'b1);
   endtask

   // mode 0: start low, ready; 1: start held; 2: start random; 3: start and ready random
   task automatic run_until_done(input int budget, input int mode);
      int n;
      logic st, mr;
      n = 0;
      while (d0_done !== 1'b1 && n < budget) begin
         st = (mode == 1) ? 1'b1 : (mode >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         mr = (mode == 3) ? (($urandom_range(0, 3)) != 0) : 1'b1;
         cycle(1'b0, st, mr);
         n++;
      end
      chk("run_done_within_budget", 64'(d0_done), 64'(1));
   endtask

   initial begin
      logic [2:0] st_hold[3];
      for (int i = 0; i < 3; i++) done_at[i] = -1;

      // reset: every output low
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      chk("reset_outputs", 64'({d0_busy, d0_done, d0_adj, d0_col, d0_mask}), 64'(0));

      // plain run; two-lane pass masks sampled in pass 0 and pass 1
      start_run();
      cycle(1'b0, 1'b0, 1'b1);
      chk("l2_pass0_col", 64'(d1_col), 64'(0));
      chk("l2_pass0_mask", 64'(d1_mask), 64'(2'b11));
      repeat (14) cycle(1'b0, 1'b0, 1'b1);
      chk("l2_pass1_col", 64'(d1_col), 64'(2));
      chk("l2_pass1_mask", 64'(d1_mask), 64'(2'b01));
      run_until_done(100, 0);
      chk("lat_default", 64'(done_at[0]), 64'(42));
      chk("lat_lanes2", 64'(done_at[1]), 64'(28));
      chk("lat_single", 64'(done_at[2]), 64'(4));
      chk("write_pulses", 64'(wr_cnt), 64'(18));
      chk("decode_pulses", 64'(dec_cnt), 64'(1));
      chk("sb_empty", 64'(exp_q.size()), 64'(0));
      cycle(1'b0, 1'b0, 1'b1);
      chk("done_drops", 64'(d0_done), 64'(0));

      // three-cycle stall in READ_ADJ at row 2, pass 0
      start_run();
      repeat (6) cycle(1'b0, 1'b0, 1'b1);
      chk("stall_pre_adj", 64'(d0_adj), 64'(2));
      st_hold = '{d0_st, d1_st, d2_st};
      repeat (3) begin
         cycle(1'b0, 1'b0, 1'b0);
         chk("stall_adj", 64'(d0_adj), 64'(2));
         chk("stall_no_write", 64'(d0_wr), 64'(0));
         chk("stall_vector", 64'(d0_vec), 64'(1));
         chk("stall_state_hold0", 64'(d0_st), 64'(st_hold[0]));
         chk("stall_state_hold1", 64'(d1_st), 64'(st_hold[1]));
         chk("stall_state_hold2", 64'(d2_st), 64'(st_hold[2]));
      end
      run_until_done(100, 0);
      chk("lat_stall", 64'(done_at[0]), 64'(45));

      // reset mid-run at row 4, pass 1, then a clean run
      start_run();
      repeat (24) cycle(1'b0, 1'b0, 1'b1);
      chk("mid_adj", 64'(d0_adj), 64'(4));
      chk("mid_col", 64'(d0_col), 64'(1));
      cycle(1'b1, 1'b0, 1'b1);
      chk("mid_reset_outputs",
          64'({d0_dec, d0_rd, d0_vec, d0_wr, d0_busy, d0_done, d0_adj, d0_col, d0_mask}), 64'(0));
      start_run();
      run_until_done(100, 0);
      chk("lat_after_reset", 64'(done_at[0]), 64'(42));
      chk("sb_empty_after_reset", 64'(exp_q.size()), 64'(0));

      // start held: done sticks with no restart; drop start, then run again
      start_run();
      run_until_done(100, 1);
      chk("lat_held", 64'(done_at[0]), 64'(42));
      repeat (5) begin
         cycle(1'b0, 1'b1, 1'b1);
         chk("held_done", 64'(d0_done), 64'(1));
         chk("held_not_busy", 64'(d0_busy), 64'(0));
      end
      cycle(1'b0, 1'b0, 1'b1);
      chk("release_done", 64'(d0_done), 64'(0));
      chk("release_busy", 64'(d0_busy), 64'(0));
      start_run();
      run_until_done(100, 0);
      chk("lat_second", 64'(done_at[0]), 64'(42));

      // start toggling while busy
      start_run();
      run_until_done(100, 2);
      chk("lat_toggle", 64'(done_at[0]), 64'(42));
      chk("toggle_decode_once", 64'(dec_cnt), 64'(1));

      // random stalls and start noise
      for (int k = 0; k < 8; k++) begin
         start_run();
         run_until_done(400, 3);
         chk("rand_sb_empty", 64'(exp_q.size()), 64'(0));
         chk("rand_writes", 64'(wr_cnt), 64'(18));
         chk("rand_decode_once", 64'(dec_cnt), 64'(1));
      end
      cycle(1'b0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout obs=running exp=finished");
      $fatal(1);
   end

endmodule

// File: doc/combination_ctrl.md
# combination_ctrl

Parametrised sequencer for the GCN combination stage. It walks every output column group of the transformed feature matrix (FM×WM) and, within each group, every adjacency row. It drives the decode, read, vector-accumulate and scratch-pad write strobes, and owns the row and column counters internally. Compared with the single-lane controller, it adds multi-lane column processing, a memory-ready stall, partial-lane masking on the last pass, and a restartable start/done handshake. It sits between the COO adjacency decoder, the FM/WM scratch pads and the aggregation datapath.

## Interface
Parameters:
- FEATURE_ROWS, 6: adjacency rows per pass; must be ≥1.
- WEIGHT_COLS, 3: output columns; must be ≥1.
- LANES, 1: columns processed in parallel per pass; 1 ≤ LANES ≤ WEIGHT_COLS.
- ROW_W, max(1,$clog2(FEATURE_ROWS)): row counter width.
- COL_W, max(1,$clog2(WEIGHT_COLS)): column base width.
- PASSES, ceil(WEIGHT_COLS/LANES): derived; not overridable.

Ports:
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- start, in, 1: level request; sampled only in IDLE and DONE.
- mem_ready, in, 1: scratch-pad read data valid this cycle.
- enable_decode, out, 1: COO decode strobe.
- enable_read, out, 1: scratch-pad read request.
- enable_vector, out, 1: accumulate adjacency row into the lane vectors.
- enable_write, out, 1: write the accumulated row to the output pad.
- adj_addr, out, ROW_W: current adjacency row.
- col_base, out, COL_W: first column of the current pass.
- lane_mask, out, LANES: bit i = 1 iff col_base+i < WEIGHT_COLS, in pass states; otherwise 0.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: high only in DONE.

## Operation
- States: IDLE, DECODE, READ_FM_WM, READ_ADJ, WRITE, NEXT_COL, DONE.
- Moore outputs, decoded from the registered state. adj_addr and col_base are registers.
- IDLE: all strobes 0; adj_addr=0; col_base=0. start=1 → DECODE.
- DECODE (1 cycle): enable_decode=1 → READ_FM_WM.
- READ_FM_WM: enable_read=1. Holds while mem_ready=0. mem_ready=1 → READ_ADJ.
- READ_ADJ: enable_read=1, enable_vector=1. Holds while mem_ready=0; enable_vector must only be consumed when mem_ready=1. mem_ready=1 → WRITE.
- WRITE (1 cycle): enable_write=1, enable_read=1. Next state:
  - adj_addr=FEATURE_ROWS-1 on the last pass → DONE.
  - adj_addr=FEATURE_ROWS-1 on any other pass → NEXT_COL.
  - otherwise adj_addr+=1 → READ_ADJ.
- NEXT_COL (1 cycle): all strobes 0; adj_addr←0; col_base←col_base+LANES → READ_FM_WM.
- Last pass is defined as col_base+LANES ≥ WEIGHT_COLS. Compute this in COL_W+1 bits so the sum cannot overflow.
- DONE: done=1, adj_addr and col_base hold their final values. start=0 → IDLE, where counters clear. start=1 → stay in DONE; there is no auto-restart.
- start is ignored in every busy state.
- reset: state←IDLE, all outputs 0 on the next edge, regardless of state. There is no partial-pass recovery.
- Counters never wrap: adj_addr ≤ FEATURE_ROWS-1 and col_base ≤ (PASSES-1)·LANES.

## Timing
- Reset values: every output 0; state IDLE.
- start high at edge k puts the block in DECODE during cycle k+1.
- With mem_ready held at 1, each pass takes 1+2·FEATURE_ROWS cycles, plus 1 for NEXT_COL between passes.
- Zero-stall latency from start sampled to done=1 is 1 + PASSES·(1+2·FEATURE_ROWS) + (PASSES-1) cycles. For defaults this is 42 cycles.
- Each mem_ready=0 cycle in READ_FM_WM or READ_ADJ adds exactly 1 cycle; outputs are stable during the stall.
- done falls one cycle after start is sampled low in DONE.
- FEATURE_ROWS=1: WRITE always sees the last row.

## Test plan
- Defaults, mem_ready=1, start pulse:
  - enable_decode high exactly 1 cycle, enable_write high 18 cycles, done at cycle 42 after start.
  - (adj_addr, col_base) visits (0..5, 0), (0..5, 1), (0..5, 2); lane_mask=1 throughout.
- LANES=2, WEIGHT_COLS=3, FEATURE_ROWS=6:
  - 2 passes, done at cycle 28.
  - col_base=0 with lane_mask=11, then col_base=2 with lane_mask=01.
- Stall: mem_ready=0 for 3 cycles in READ_ADJ at row 2, pass 0.
  - State, adj_addr and strobes hold for those cycles; no enable_write pulse during the stall.
  - done arrives at cycle 45.
- Reset mid-run at row 4, pass 1: next cycle all outputs 0 and state IDLE. A subsequent start gives a clean 42-cycle run.
- Handshake:
  - start held high through the whole run: done stays high and there is no restart.
  - start dropped: IDLE next cycle; a second start completes again.
  - start toggling while busy has no effect.
- FEATURE_ROWS=1, WEIGHT_COLS=1, LANES=1: DECODE, READ_FM_WM, READ_ADJ, WRITE, DONE, with done at cycle 4.
